// File: rtl/reg_pipe_elastic.sv
// Stallable, flushable multi-stage pipeline register with per-stage valid bits.
// Stages advance independently, so bubbles collapse when the output is stalled.
module reg_pipe_elastic #(
  parameter int               WIDTH   = 16,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] load;
  logic [OW-1:0]    occ_d;

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high. valid never waits on ready; ready may depend combinationally on the
  // downstream ready (out_ready -> in_ready) and on flush, nothing else.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = out_ready | ~valid_q[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = rdy[i+1] | ~valid_q[i];
    end
  end

  // Each stage is fed by the one before it; stage 0 is fed by the input port.
  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    for (int i = 0; i < DEPTH; i++) begin
      src_data[i] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  // Data only moves with a valid item, so bubbles never disturb held data.
  always_comb begin
    valid_d = valid_q;
    load    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
      end else if (rdy[i]) begin
        valid_d[i] = src_valid[i];
        load[i]    = src_valid[i];
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
    end else begin
      valid_q   <= valid_d;
      occupancy <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          data_q[i] <= src_data[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// Directed bench for reg_pipe_elastic: a DEPTH=3 and a DEPTH=1 instance share
// stimulus; each vector selects which instance's outputs are checked.
module tb_reg_pipe_elastic;

  localparam int               W  = 16;
  localparam logic [W-1:0]     RV = 16'hA5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       = 1'b1;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data   = '0;

  logic         in_ready3, out_valid3;
  logic [W-1:0] out_data3;
  logic [1:0]   occ3;
  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [0:0]   occ1;

  reg_pipe_elastic #(.WIDTH(W), .DEPTH(3), .RST_VAL(RV)) dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .occupancy(occ3)
  );

  reg_pipe_elastic #(.WIDTH(W), .DEPTH(1), .RST_VAL(RV)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  typedef struct {
    string        name;
    bit           sel;
    bit           rst;
    bit           flush;
    bit           iv;
    logic [W-1:0] id;
    bit           ordy;
    bit           chk;
    bit           e_ir;
    bit           e_ov;
    logic [W-1:0] e_od;
    int           e_occ;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  bit   seen55 = 1'b0;

  always @(negedge clk) begin
    if (out_valid3 && out_data3 == 16'h0055) seen55 = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input bit sel, input bit r, input bit f,
                     input bit iv, input logic [W-1:0] id, input bit ordy,
                     input bit chk, input bit e_ir, input bit e_ov,
                     input logic [W-1:0] e_od, input int e_occ);
    vec_t v;
    v.name = name; v.sel = sel; v.rst = r; v.flush = f; v.iv = iv; v.id = id;
    v.ordy = ordy; v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, sample at the falling edge, then cross the rising edge.
  task automatic apply(input vec_t v);
    rst = v.rst; flush = v.flush; in_valid = v.iv; in_data = v.id;
    out_ready = v.ordy;
    @(negedge clk);
    if (v.chk) begin
      if (v.sel) begin
        check({v.name, ".in_ready"},  int'(in_ready1),  int'(v.e_ir));
        check({v.name, ".out_valid"}, int'(out_valid1), int'(v.e_ov));
        check({v.name, ".out_data"},  int'(out_data1),  int'(v.e_od));
        check({v.name, ".occ"},       int'(occ1),       v.e_occ);
      end else begin
        check({v.name, ".in_ready"},  int'(in_ready3),  int'(v.e_ir));
        check({v.name, ".out_valid"}, int'(out_valid3), int'(v.e_ov));
        check({v.name, ".out_data"},  int'(out_data3),  int'(v.e_od));
        check({v.name, ".occ"},       int'(occ3),       v.e_occ);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input bit sel, input bit r, input bit f,
                     input bit iv, input logic [W-1:0] id, input bit ordy,
                     input bit chk, input bit e_ir, input bit e_ov,
                     input logic [W-1:0] e_od, input int e_occ);
    vec_t v;
    v.name = name; v.sel = sel; v.rst = r; v.flush = f; v.iv = iv; v.id = id;
    v.ordy = ordy; v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    v.e_occ = e_occ;
    apply(v);
  endtask

  initial begin
    //   name      sel rst fl iv data  ordy chk ir ov out_data occ
    add("reset",    0, 1, 0, 0, 0,     0,   0,  0, 0, RV,      0);
    add("t1_idle",  0, 0, 0, 0, 0,     0,   1,  1, 0, RV,      0);
    // stream 1..8 at full rate
    add("t2_c0",    0, 0, 0, 1, 1,     1,   1,  1, 0, RV,      0);
    add("t2_c1",    0, 0, 0, 1, 2,     1,   1,  1, 0, RV,      1);
    add("t2_c2",    0, 0, 0, 1, 3,     1,   1,  1, 0, RV,      2);
    add("t2_c3",    0, 0, 0, 1, 4,     1,   1,  1, 1, 1,       3);
    add("t2_c4",    0, 0, 0, 1, 5,     1,   1,  1, 1, 2,       3);
    add("t2_c5",    0, 0, 0, 1, 6,     1,   1,  1, 1, 3,       3);
    add("t2_c6",    0, 0, 0, 1, 7,     1,   1,  1, 1, 4,       3);
    add("t2_c7",    0, 0, 0, 1, 8,     1,   1,  1, 1, 5,       3);
    add("t2_c8",    0, 0, 0, 0, 0,     1,   1,  1, 1, 6,       3);
    add("t2_c9",    0, 0, 0, 0, 0,     1,   1,  1, 1, 7,       2);
    add("t2_c10",   0, 0, 0, 0, 0,     1,   1,  1, 1, 8,       1);
    add("t2_c11",   0, 0, 0, 0, 0,     1,   1,  1, 0, 8,       0);
    // backpressure: fill to 3, 4th refused until out_ready rises
    add("t3_c0",    0, 0, 0, 1, 1,     0,   1,  1, 0, 8,       0);
    add("t3_c1",    0, 0, 0, 1, 2,     0,   1,  1, 0, 8,       1);
    add("t3_c2",    0, 0, 0, 1, 3,     0,   1,  1, 0, 8,       2);
    add("t3_c3",    0, 0, 0, 1, 4,     0,   1,  0, 1, 1,       3);
    add("t3_c4",    0, 0, 0, 1, 4,     1,   1,  1, 1, 1,       3);
    add("t3_c5",    0, 0, 0, 0, 0,     1,   1,  1, 1, 2,       3);
    add("t3_c6",    0, 0, 0, 0, 0,     1,   1,  1, 1, 3,       2);
    add("t3_c7",    0, 0, 0, 0, 0,     1,   1,  1, 1, 4,       1);
    add("t3_c8",    0, 0, 0, 0, 0,     1,   1,  1, 0, 4,       0);
    // bubble collapse under a stalled output
    add("t4_c0",    0, 0, 0, 1, 7,     0,   1,  1, 0, 4,       0);
    add("t4_c1",    0, 0, 0, 0, 0,     0,   1,  1, 0, 4,       1);
    add("t4_c2",    0, 0, 0, 0, 0,     0,   1,  1, 0, 4,       1);
    add("t4_c3",    0, 0, 0, 1, 9,     0,   1,  1, 1, 7,       1);
    add("t4_c4",    0, 0, 0, 0, 0,     0,   1,  1, 1, 7,       2);
    add("t4_c5",    0, 0, 0, 0, 0,     0,   1,  1, 1, 7,       2);
    add("t4_c6",    0, 0, 0, 0, 0,     1,   1,  1, 1, 7,       2);
    add("t4_c7",    0, 0, 0, 0, 0,     1,   1,  1, 1, 9,       1);
    add("t4_c8",    0, 0, 0, 0, 0,     1,   1,  1, 0, 9,       0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // flush while full with a pending input: nothing transfers, all dropped
    cyc("t5_c0",    0, 0, 0, 1, 16'h11, 0, 1, 1, 0, 9,      0);
    cyc("t5_c1",    0, 0, 0, 1, 16'h22, 0, 1, 1, 0, 9,      1);
    cyc("t5_c2",    0, 0, 0, 1, 16'h33, 0, 1, 1, 0, 9,      2);
    cyc("t5_flush", 0, 0, 1, 1, 16'h55, 1, 1, 0, 0, 16'h11, 3);
    cyc("t5_c4",    0, 0, 0, 0, 0,      1, 1, 1, 0, 16'h11, 0);
    cyc("t5_c5",    0, 0, 0, 0, 0,      1, 1, 1, 0, 16'h11, 0);

    // reset with flush while streaming
    cyc("t6_c0",    0, 0, 0, 1, 16'h101, 1, 1, 1, 0, 16'h11,  0);
    cyc("t6_c1",    0, 0, 0, 1, 16'h102, 1, 1, 1, 0, 16'h11,  1);
    cyc("t6_c2",    0, 0, 0, 1, 16'h103, 1, 1, 1, 0, 16'h11,  2);
    cyc("t6_rst",   0, 1, 1, 1, 16'h104, 1, 1, 0, 0, 16'h101, 3);
    cyc("t6_after", 0, 0, 0, 0, 0,       1, 1, 1, 0, RV,      0);
    check("t5_no55", int'(seen55), 0);

    // DEPTH=1: latency 1, one item per cycle
    cyc("d1_rst",   1, 1, 0, 0, 0, 1, 0, 0, 0, RV, 0);
    cyc("d1_c0",    1, 0, 0, 1, 1, 1, 1, 1, 0, RV, 0);
    cyc("d1_c1",    1, 0, 0, 1, 2, 1, 1, 1, 1, 1,  1);
    cyc("d1_c2",    1, 0, 0, 1, 3, 1, 1, 1, 1, 2,  1);
    cyc("d1_c3",    1, 0, 0, 1, 4, 1, 1, 1, 1, 3,  1);
    cyc("d1_c4",    1, 0, 0, 0, 0, 0, 1, 0, 1, 4,  1);
    cyc("d1_c5",    1, 0, 0, 0, 0, 1, 1, 1, 1, 4,  1);
    cyc("d1_c6",    1, 0, 0, 0, 0, 1, 1, 1, 0, 4,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
